// File: rtl/io_pulse_pkg.sv
// Shared types and elaboration helpers for the io_pulse_driver block.
package io_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } pulse_state_e;

  function automatic bit params_ok(input int high_cycles, input int low_cycles,
                                   input int queue_depth);
    return (high_cycles >= 1) && (low_cycles >= 1) && (queue_depth >= 1);
  endfunction

endpackage

// File: rtl/io_pulse_driver_cycle_timer.sv
// Enable-gated down-counter; a load wins over the decrement and the count parks at zero.
module cycle_timer #(
  parameter int Timer_Width = 5
) (
  input  logic                   clk,
  input  logic                   clk_en,
  input  logic                   async_rst_n,
  input  logic                   load,
  input  logic [Timer_Width-1:0] load_value,
  output logic                   expired
);

  logic [Timer_Width-1:0] count_d;
  logic [Timer_Width-1:0] count_q;

  // Next count: load, decrement towards zero, or hold.
  always_comb begin
    count_d = count_q;
    if (clk_en && load) begin
      count_d = load_value;
    end else if (clk_en && (count_q != {Timer_Width{1'b0}})) begin
      count_d = count_q - Timer_Width'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      count_q <= {Timer_Width{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == {Timer_Width{1'b0}});

endmodule

// File: rtl/io_pulse_driver.sv
// Turns single-cycle event pulses into timed high phases with a guaranteed low gap,
// replaying events that arrive mid-pulse from a small pending counter.
module io_pulse_driver
  import io_pulse_pkg::*;
#(
  parameter  int High_Cycles = 20,
  parameter  int Low_Cycles  = 10,
  parameter  int Queue_Depth = 4,
  localparam int Timer_Width = $clog2(((High_Cycles > Low_Cycles) ? High_Cycles : Low_Cycles) + 1),
  localparam int Count_Width = $clog2(Queue_Depth + 1)
) (
  input  logic                   clk,
  input  logic                   async_rst_n,
  input  logic                   clk_en,
  input  logic                   trigger_in,
  input  logic                   abort,
  output logic                   io_out,
  output logic                   busy,
  output logic [Count_Width-1:0] pending_count,
  output logic                   overflow
);

  if (!params_ok(High_Cycles, Low_Cycles, Queue_Depth)) begin : g_param_check
    $error("io_pulse_driver: High_Cycles, Low_Cycles and Queue_Depth must all be >= 1");
  end

  localparam logic [Timer_Width-1:0] HighLoad = Timer_Width'(High_Cycles - 1);
  localparam logic [Timer_Width-1:0] LowLoad  = Timer_Width'(Low_Cycles - 1);
  localparam logic [Count_Width-1:0] DepthMax = Count_Width'(Queue_Depth);
  localparam logic [Count_Width-1:0] CountOne = Count_Width'(1);
  localparam logic [Count_Width-1:0] CountNil = Count_Width'(0);

  pulse_state_e           state_d, state_q;
  logic [Count_Width-1:0] pend_d, pend_q;
  logic                   io_d, io_q;
  logic                   ovf_d, ovf_q;
  logic                   tmr_load;
  logic [Timer_Width-1:0] tmr_value;
  logic                   tmr_expired;

  cycle_timer #(.Timer_Width(Timer_Width)) u_timer (
    .clk        (clk),
    .clk_en     (clk_en),
    .async_rst_n(async_rst_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expired    (tmr_expired)
  );

  // Next-state, pending queue and pin drive; abort outranks any trigger.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    io_d      = io_q;
    ovf_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = LowLoad;
    if (!clk_en) begin
      ovf_d = 1'b0;
    end else if (abort) begin
      pend_d = CountNil;
      if (state_q == HIGH) begin
        state_d  = GAP;
        io_d     = 1'b0;
        tmr_load = 1'b1;
      end else begin
        state_d = state_q;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger_in) begin
            state_d   = HIGH;
            io_d      = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = HighLoad;
          end else begin
            state_d = IDLE;
          end
        end
        HIGH: begin
          if (tmr_expired) begin
            state_d  = GAP;
            io_d     = 1'b0;
            tmr_load = 1'b1;
          end else begin
            state_d = HIGH;
          end
          if (trigger_in && (pend_q < DepthMax)) begin
            pend_d = pend_q + CountOne;
          end else if (trigger_in) begin
            ovf_d = 1'b1;
          end else begin
            pend_d = pend_q;
          end
        end
        GAP: begin
          // A trigger on the replay cycle takes the slot the replayed event frees.
          if (tmr_expired && (pend_q != CountNil)) begin
            state_d   = HIGH;
            io_d      = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = HighLoad;
            pend_d    = trigger_in ? pend_q : (pend_q - CountOne);
          end else if (tmr_expired && trigger_in) begin
            state_d   = HIGH;
            io_d      = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = HighLoad;
          end else if (tmr_expired) begin
            state_d = IDLE;
          end else if (trigger_in && (pend_q < DepthMax)) begin
            pend_d = pend_q + CountOne;
          end else if (trigger_in) begin
            ovf_d = 1'b1;
          end else begin
            state_d = GAP;
          end
        end
        default: begin
          state_d = IDLE;
          io_d    = 1'b0;
          pend_d  = CountNil;
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= IDLE;
      pend_q  <= CountNil;
      io_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      io_q    <= io_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io_out        = io_q;
  assign busy          = (state_q != IDLE);
  assign pending_count = pend_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_io_pulse_driver.sv
// Directed bench for io_pulse_driver: pulse scoreboard plus cycle-exact spot checks.
module tb_io_pulse_driver;

  localparam int HC = 20;
  localparam int LC = 10;
  localparam int QD = 4;

  logic       clk = 1'b0;
  logic       async_rst_n;
  logic       clk_en;
  logic       trigger_in;
  logic       abort;
  logic       io_out;
  logic       busy;
  logic [2:0] pending_count;
  logic       overflow;

  io_pulse_driver #(.High_Cycles(HC), .Low_Cycles(LC), .Queue_Depth(QD)) dut (
    .clk          (clk),
    .async_rst_n  (async_rst_n),
    .clk_en       (clk_en),
    .trigger_in   (trigger_in),
    .abort        (abort),
    .io_out       (io_out),
    .busy         (busy),
    .pending_count(pending_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int start;
    int len;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t got;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  int     n_fail = 0;
  int     ovf_cnt = 0;
  logic   io_prev = 1'b0;
  int     rise_cyc = 0;
  int     hi_len = 0;
  int     c0;
  int     base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pulse(input int start, input int len);
    pulse_t p;
    p.start = start;
    p.len   = len;
    exp_q.push_back(p);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, busy, 1'b0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: measures each high phase in raw clocks and scores it.
  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_cnt++;
    if (io_out === 1'b1) begin
      if (io_prev !== 1'b1) begin
        rise_cyc = cyc;
        hi_len   = 0;
      end
      hi_len++;
    end else if (io_prev === 1'b1) begin
      chk("pulse_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk("pulse_start", rise_cyc, got.start);
        chk("pulse_len", hi_len, got.len);
      end
    end
    io_prev = io_out;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    async_rst_n = 1'b0;
    clk_en      = 1'b1;
    trigger_in  = 1'b0;
    abort       = 1'b0;
    step(3);
    chk("rst_io", io_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pend", pending_count, 3'd0);
    chk("rst_ovf", overflow, 1'b0);
    async_rst_n = 1'b1;
    step(2);

    // Single trigger
    c0 = cyc;
    trigger_in = 1'b1;
    push_pulse(c0 + 1, HC);
    step(1);
    trigger_in = 1'b0;
    chk("t1_io_rise", io_out, 1'b1);
    chk("t1_busy", busy, 1'b1);
    step(19);
    chk("t1_io_last_high", io_out, 1'b1);
    step(1);
    chk("t1_io_gap", io_out, 1'b0);
    chk("t1_busy_gap", busy, 1'b1);
    step(9);
    chk("t1_busy_gap_end", busy, 1'b1);
    step(1);
    chk("t1_idle", busy, 1'b0);
    chk("t1_pend", pending_count, 3'd0);

    // Three triggers, two queued
    step(2);
    c0 = cyc;
    trigger_in = 1'b1;
    push_pulse(c0 + 1, HC);
    step(1);
    trigger_in = 1'b0;
    step(2);
    trigger_in = 1'b1;
    push_pulse(c0 + 31, HC);
    step(1);
    trigger_in = 1'b0;
    chk("t2_pend1", pending_count, 3'd1);
    step(3);
    trigger_in = 1'b1;
    push_pulse(c0 + 61, HC);
    step(1);
    trigger_in = 1'b0;
    chk("t2_pend2", pending_count, 3'd2);
    step(22);
    chk("t2_gap_io", io_out, 1'b0);
    chk("t2_gap_pend", pending_count, 3'd2);
    step(1);
    chk("t2_replay_io", io_out, 1'b1);
    chk("t2_replay_pend", pending_count, 3'd1);
    step(30);
    chk("t2_third_pend", pending_count, 3'd0);
    wait_idle("t2_idle", 40);

    // Saturation, overflow, and full-queue accept at gap end
    step(2);
    c0 = cyc;
    base = ovf_cnt;
    for (int k = 0; k < 6; k++) push_pulse(c0 + 1 + 30 * k, HC);
    trigger_in = 1'b1;
    step(7);
    trigger_in = 1'b0;
    chk("t3_pend_sat", pending_count, 3'd4);
    step(1);
    chk("t3_ovf_count", ovf_cnt - base, 32'd2);
    step(22);
    chk("t3_pend_before", pending_count, 3'd4);
    trigger_in = 1'b1;
    step(1);
    trigger_in = 1'b0;
    chk("t3_full_accept_pend", pending_count, 3'd4);
    chk("t3_full_accept_ovf", overflow, 1'b0);
    chk("t3_full_accept_io", io_out, 1'b1);
    wait_idle("t3_idle", 200);
    chk("t3_ovf_total", ovf_cnt - base, 32'd2);

    // Abort mid-pulse with two pending, same-cycle trigger discarded
    step(2);
    c0 = cyc;
    base = ovf_cnt;
    trigger_in = 1'b1;
    push_pulse(c0 + 1, 10);
    step(3);
    trigger_in = 1'b0;
    chk("t4_pend2", pending_count, 3'd2);
    step(7);
    abort      = 1'b1;
    trigger_in = 1'b1;
    step(1);
    abort      = 1'b0;
    trigger_in = 1'b0;
    chk("t4_abort_io", io_out, 1'b0);
    chk("t4_abort_pend", pending_count, 3'd0);
    chk("t4_abort_ovf", overflow, 1'b0);
    chk("t4_abort_busy", busy, 1'b1);
    step(9);
    chk("t4_gap_busy", busy, 1'b1);
    step(1);
    chk("t4_idle", busy, 1'b0);
    chk("t4_ovf_none", ovf_cnt - base, 32'd0);

    // clk_en toggling; triggers while disabled are ignored
    step(2);
    clk_en     = 1'b0;
    trigger_in = 1'b1;
    step(1);
    chk("t5_dis_trig_busy", busy, 1'b0);
    c0 = cyc;
    clk_en = 1'b1;
    push_pulse(c0 + 1, 2 * HC);
    step(1);
    trigger_in = 1'b0;
    for (int i = 0; i < 70; i++) begin
      clk_en     = (i % 2 == 1);
      trigger_in = (i % 2 == 0);
      step(1);
      if (i == 38) chk("t5_io_last_high", io_out, 1'b1);
      if (i == 39) chk("t5_io_low", io_out, 1'b0);
    end
    clk_en     = 1'b1;
    trigger_in = 1'b0;
    chk("t5_idle", busy, 1'b0);
    chk("t5_pend", pending_count, 3'd0);

    // Asynchronous reset mid-pulse, then a fresh full pulse
    step(2);
    c0 = cyc;
    trigger_in = 1'b1;
    push_pulse(c0 + 1, 4);
    step(2);
    trigger_in = 1'b0;
    chk("t6_pend1", pending_count, 3'd1);
    step(3);
    #2;
    async_rst_n = 1'b0;
    #1;
    chk("t6_rst_io", io_out, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_pend", pending_count, 3'd0);
    async_rst_n = 1'b1;
    step(2);
    c0 = cyc;
    trigger_in = 1'b1;
    push_pulse(c0 + 1, HC);
    step(1);
    trigger_in = 1'b0;
    chk("t6_restart_io", io_out, 1'b1);
    step(20);
    chk("t6_restart_gap", io_out, 1'b0);
    wait_idle("t6_idle", 20);

    step(2);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
